pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Owns the program counter and sequences instruction fetch for the CPU core.
- Issues fetch requests to instruction memory and presents fetched instructions to decode with a valid/ready handshake.
- Applies redirects from the Branch unit (shouldUseNewPC/branchTo), with an optional MIPS-style branch delay slot.
- Sits between instruction memory, decode and Branch; feeds pcAddress back to Branch for offset computation.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- DELAY_SLOT, 1, 1 = the instruction after a taken branch always issues; 0 = redirect squashes it.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- stall  in  1  pipeline hold from downstream
- fetchReq  out  1  instruction memory request
- fetchAddress  out  32  word address being fetched
- fetchAck  in  1  memory returns fetchData this cycle
- fetchData  in  32  instruction word
- instruction  out  32  instruction presented to decode
- instructionPC  out  32  address of presented instruction
- instructionValid  out  1  instruction/instructionPC valid
- instructionReady  in  1  decode accepts this cycle
- pcAddress  out  32  instructionPC + 4, to Branch
- branchValid  in  1  Branch resolution for the most recently accepted instruction
- shouldUseNewPC  in  1  branch taken
- branchTo  in  32  redirect target
- addrError  out  1  sticky misaligned-target flag

Behaviour:
- Reset (rst low, asynchronous):
  - pc=RESET_PC; state=IDLE.
  - fetchReq=0, fetchAddress=RESET_PC, instruction=0, instructionPC=RESET_PC, instructionValid=0, addrError=0.
  - Pending-redirect register cleared; squash flag cleared.
- Reset mid-operation: everything returns to the reset values immediately. Any outstanding memory request is abandoned; a late fetchAck is ignored.
- State IDLE: moves to FETCH on the first clock edge after rst goes high.
- State FETCH:
  - While stall=0, fetchReq=1 and fetchAddress=pc.
  - Once fetchReq is asserted it stays high, with fetchAddress stable, until fetchAck, even if stall rises.
  - On fetchAck, fetchData is registered into instruction, pc into instructionPC, instructionValid=1 next cycle, state goes to ISSUE.
  - Fetch latency = 1 cycle after ack.
- State ISSUE:
  - instructionValid stays high and data is held until instructionReady=1 and stall=0 (accept).
  - On accept, instructionValid=0 next cycle unless immediately refetching, and state goes to FETCH with the next pc.
- Next pc on accept:
  - With no pending redirect, pc = instructionPC + 4, modulo 2^32 (32'hFFFFFFFC wraps to 0).
- Redirect capture: branchValid=1 with shouldUseNewPC=1 latches {branchTo[31:2],2'b00} as pending target. branchValid with shouldUseNewPC=0 has no effect.
- DELAY_SLOT=1:
  - The delay slot (next sequential instruction) is fetched and issued normally; its accept loads pc = pending target and clears pending.
  - If branchValid arrives in the same cycle as the delay slot's accept, pc = branchTo directly.
- DELAY_SLOT=0:
  - In ISSUE, an unaccepted instruction is squashed: instructionValid=0 next cycle, pc=target, state goes to FETCH.
  - In FETCH with a request outstanding, the fetch completes but its data is discarded (instructionValid stays 0), then the target is fetched.
  - In FETCH with no request yet, the target is fetched directly.
- branchTo[1:0] != 0 sets addrError=1 (sticky until reset); the target is still used with low bits forced to zero.
- A second redirect before the pending one is consumed overwrites it (last wins).
- pcAddress = instructionPC + 4 combinationally, with the same wrap rule.
- Stall does not block redirect capture.

Test Plan:
- Reset/sequential: RESET_PC=0, memory acks every request in 1 cycle, ready=1 → fetchAddress 0,4,8,C in order; the first instructionValid arrives 3 cycles after reset release; all outputs at reset values while rst=0.
- Delay-slot branch: DELAY_SLOT=1, accept at PC 0x100, branchValid with branchTo=0x200 → 0x104 is issued, then fetchAddress=0x200, pcAddress=0x204 when 0x200 is presented.
- Squash: DELAY_SLOT=0, instruction at 0x104 presented with ready=0, redirect to 0x300 → 0x104 is never accepted, the next fetchAddress is 0x300, addrError=0.
- Outstanding fetch redirect: DELAY_SLOT=0, redirect to 0x40 while fetchReq for 0x108 waits 3 cycles for ack → the 0x108 data is dropped, then fetchAddress=0x40.
- Stall/wrap: pc=32'hFFFFFFFC, stall=1 for 4 cycles after fetchReq is raised → fetchReq stays held and instruction is not accepted during stall; after release the next fetchAddress is 0.
- Misaligned target and async reset: branchTo=0xAABBCCDF → the target fetched is 0xAABBCCDC and addrError=1. Asserting rst low mid-fetch with a late fetchAck → instructionValid stays 0 and fetchAddress=RESET_PC.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter and instruction fetch sequencer with branch redirect and optional delay slot
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter bit DELAY_SLOT = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  output logic        fetchReq,
  output logic [31:0] fetchAddress,
  input  logic        fetchAck,
  input  logic [31:0] fetchData,
  output logic [31:0] instruction,
  output logic [31:0] instructionPC,
  output logic        instructionValid,
  input  logic        instructionReady,
  output logic [31:0] pcAddress,
  input  logic        branchValid,
  input  logic        shouldUseNewPC,
  input  logic [31:0] branchTo,
  output logic        addrError
);
  typedef enum logic [1:0] {IDLE, FETCH, ISSUE} state_t;
  state_t state, stateNext;
  logic [31:0] pc, pcNext, target, targetNext, instrNext, instrPCNext, redirectPC;
  logic held, heldNext, pending, pendingNext, squash, squashNext, validNext, errNext;
  logic redirect, accept;
  assign redirect = branchValid & shouldUseNewPC;
  assign redirectPC = {branchTo[31:2], 2'b00};
  assign accept = (state == ISSUE) & instructionReady & ~stall;
  assign fetchReq = (state == FETCH) & (held | ~stall);
  assign fetchAddress = pc;
  assign pcAddress = instructionPC + 32'd4;
  always_comb begin
    stateNext = state;
    pcNext = pc;
    targetNext = redirect ? redirectPC : target;
    pendingNext = pending | (redirect & DELAY_SLOT);
    squashNext = squash;
    heldNext = held;
    instrNext = instruction;
    instrPCNext = instructionPC;
    validNext = instructionValid;
    errNext = addrError | (redirect & |branchTo[1:0]);
    case (state)
      IDLE: begin
        stateNext = FETCH;
        pcNext = (!DELAY_SLOT && redirect) ? redirectPC : pc;
      end
      FETCH: begin
        heldNext = fetchReq & ~fetchAck;
        if (fetchReq && fetchAck) begin
          // a request issued before a redirect completes, but its data is thrown away
          if (squash || (!DELAY_SLOT && redirect)) begin
            pcNext = redirect ? redirectPC : target;
            squashNext = 1'b0;
          end else begin
            instrNext = fetchData;
            instrPCNext = pc;
            validNext = 1'b1;
            stateNext = ISSUE;
          end
        end else if (!DELAY_SLOT && redirect) begin
          squashNext = fetchReq;
          pcNext = fetchReq ? pc : redirectPC;
        end
      end
      ISSUE: begin
        if (!DELAY_SLOT && redirect) begin
          validNext = 1'b0;
          pcNext = redirectPC;
          stateNext = FETCH;
        end else if (accept) begin
          validNext = 1'b0;
          stateNext = FETCH;
          pcNext = redirect ? redirectPC : pending ? target : instructionPC + 32'd4;
          pendingNext = 1'b0;
        end
      end
      default: stateNext = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      pc <= RESET_PC;
      target <= '0;
      pending <= 1'b0;
      squash <= 1'b0;
      held <= 1'b0;
      instruction <= '0;
      instructionPC <= RESET_PC;
      instructionValid <= 1'b0;
      addrError <= 1'b0;
    end else begin
      state <= stateNext;
      pc <= pcNext;
      target <= targetNext;
      pending <= pendingNext;
      squash <= squashNext;
      held <= heldNext;
      instruction <= instrNext;
      instructionPC <= instrPCNext;
      instructionValid <= validNext;
      addrError <= errNext;
    end
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed scoreboard bench driving a delay-slot and a squashing instance in turn
module tb_pc_sequencer;
  logic clk = 1'b0, sel = 1'b1, stall = 1'b0, fetchAck = 1'b0, instructionReady = 1'b1;
  logic branchValid = 1'b0, shouldUseNewPC = 1'b0;
  logic [1:0] rstN = 2'b00;
  logic [31:0] fetchData = '0, branchTo = '0;
  logic frA [2], ivA [2], aeA [2];
  logic [31:0] faA [2], insA [2], ipcA [2], pcaA [2];
  logic fetchReq, instructionValid, addrError;
  logic [31:0] fetchAddress, instruction, instructionPC, pcAddress;
  int total = 0, bad = 0, lat = 1, cnt = 0;
  logic [31:0] expPC [$], expFetch [$];
  always #5 clk = ~clk;
  for (genvar i = 0; i < 2; i++) begin : g
    pc_sequencer #(.RESET_PC(32'h0), .DELAY_SLOT(i == 1)) dut (
      .clk(clk), .rst(rstN[i]), .stall(stall),
      .fetchReq(frA[i]), .fetchAddress(faA[i]), .fetchAck(fetchAck), .fetchData(fetchData),
      .instruction(insA[i]), .instructionPC(ipcA[i]), .instructionValid(ivA[i]),
      .instructionReady(instructionReady), .pcAddress(pcaA[i]),
      .branchValid(branchValid), .shouldUseNewPC(shouldUseNewPC), .branchTo(branchTo),
      .addrError(aeA[i])
    );
  end
  assign fetchReq = frA[sel];
  assign fetchAddress = faA[sel];
  assign instruction = insA[sel];
  assign instructionPC = ipcA[sel];
  assign instructionValid = ivA[sel];
  assign pcAddress = pcaA[sel];
  assign addrError = aeA[sel];
  function automatic logic [31:0] dataOf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h required=%h", tag, got, exp);
    end
  endtask
  // one clock: memory and scoreboard act at negedge, directed steps resume just after posedge
  task automatic cyc();
    logic [31:0] e;
    @(negedge clk);
    if (fetchAck) fetchAck = 1'b0;
    else if (fetchReq) begin
      if (cnt == lat) begin
        fetchAck = 1'b1;
        fetchData = dataOf(fetchAddress);
        cnt = 0;
        total++;
        assert (expFetch.size() != 0) else begin
          bad++;
          $error("FAIL fetchOrder got=%h required=none", fetchAddress);
        end
        if (expFetch.size() != 0) begin
          e = expFetch.pop_front();
          chk("fetchAddr", fetchAddress, e);
        end
      end else cnt++;
    end
    if (instructionValid && instructionReady && !stall) begin
      total++;
      assert (expPC.size() != 0) else begin
        bad++;
        $error("FAIL issueOrder got=%h required=none", instructionPC);
      end
      if (expPC.size() != 0) begin
        e = expPC.pop_front();
        chk("issuePC", instructionPC, e);
        chk("issueData", instruction, dataOf(e));
      end
    end
    @(posedge clk);
    #1;
  endtask
  task automatic drain();
    int n = 0;
    while ((expPC.size() != 0 || expFetch.size() != 0) && n < 60) begin
      cyc();
      n++;
    end
    total++;
    assert (expPC.size() == 0 && expFetch.size() == 0) else begin
      bad++;
      $error("FAIL drainTimeout pcLeft=%0d fetchLeft=%0d required=0", expPC.size(), expFetch.size());
    end
  endtask
  task automatic resetChecks();
    chk("rstReq", fetchReq, 0);
    chk("rstAddr", fetchAddress, 0);
    chk("rstInstr", instruction, 0);
    chk("rstIPC", instructionPC, 0);
    chk("rstValid", instructionValid, 0);
    chk("rstErr", addrError, 0);
    chk("rstPcAddr", pcAddress, 32'h4);
  endtask
  task automatic branch(input logic [31:0] t, input logic taken);
    branchTo = t;
    shouldUseNewPC = taken;
    branchValid = 1'b1;
    cyc();
    branchValid = 1'b0;
    shouldUseNewPC = 1'b0;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    resetChecks();
    for (int a = 0; a < 16; a += 4) begin
      expFetch.push_back(32'(a));
      expPC.push_back(32'(a));
    end
    rstN[1] = 1'b1;
    cyc();
    cyc();
    chk("validEarly", instructionValid, 0);
    cyc();
    chk("validAt3", instructionValid, 1);
    chk("firstIPC", instructionPC, 0);
    drain();
    stall = 1'b1;
    branch(32'h500, 1'b0);
    branch(32'h100, 1'b1);
    chk("dsHoldAddr", fetchAddress, 32'h10);
    stall = 1'b0;
    expFetch.push_back(32'h10); expPC.push_back(32'h10);
    expFetch.push_back(32'h100); expPC.push_back(32'h100);
    drain();
    branch(32'h200, 1'b1);
    expFetch.push_back(32'h104); expPC.push_back(32'h104); expFetch.push_back(32'h200);
    drain();
    instructionReady = 1'b0;
    chk("dsTargetIPC", instructionPC, 32'h200);
    chk("dsPcAddr", pcAddress, 32'h204);
    chk("dsValid", instructionValid, 1);
    instructionReady = 1'b1;
    expPC.push_back(32'h200);
    branch(32'h280, 1'b1);
    chk("sameCycleAddr", fetchAddress, 32'h280);
    expFetch.push_back(32'h280);
    drain();
    instructionReady = 1'b0;
    chk("sameCycleIPC", instructionPC, 32'h280);
    instructionReady = 1'b1;
    expPC.push_back(32'h280);
    branch(32'hFFFF_FFFC, 1'b1);
    lat = 2;
    expFetch.push_back(32'hFFFF_FFFC);
    cyc();
    stall = 1'b1;
    chk("holdReq", fetchReq, 1);
    cyc();
    chk("holdReq2", fetchReq, 1);
    chk("holdAddr", fetchAddress, 32'hFFFF_FFFC);
    cyc();
    chk("stallValid", instructionValid, 1);
    cyc();
    cyc();
    chk("stallHeld", instructionValid, 1);
    chk("stallIPC", instructionPC, 32'hFFFF_FFFC);
    chk("wrapPcAddr", pcAddress, 0);
    stall = 1'b0;
    lat = 1;
    expPC.push_back(32'hFFFF_FFFC); expFetch.push_back(32'h0);
    drain();
    instructionReady = 1'b0;
    chk("wrapIPC", instructionPC, 0);
    instructionReady = 1'b1;
    expPC.push_back(32'h0);
    cyc();
    lat = 5;
    cyc();
    rstN[1] = 1'b0;
    #1;
    resetChecks();
    cnt = 0;
    fetchAck = 1'b1;
    fetchData = 32'hBAD0_BAD0;
    rstN[1] = 1'b1;
    @(posedge clk);
    #1;
    fetchAck = 1'b0;
    chk("lateAckValid", instructionValid, 0);
    chk("lateAckAddr", fetchAddress, 0);
    chk("lateAckInstr", instruction, 0);
    rstN[1] = 1'b0;
    sel = 1'b0;
    #1;
    resetChecks();
    stall = 1'b1;
    instructionReady = 1'b0;
    lat = 1;
    cnt = 0;
    rstN[0] = 1'b1;
    cyc();
    branch(32'h100, 1'b1);
    chk("directAddr", fetchAddress, 32'h100);
    chk("directNoReq", fetchReq, 0);
    stall = 1'b0;
    instructionReady = 1'b1;
    expFetch.push_back(32'h100); expPC.push_back(32'h100); expFetch.push_back(32'h104);
    drain();
    instructionReady = 1'b0;
    chk("presentValid", instructionValid, 1);
    chk("presentIPC", instructionPC, 32'h104);
    branch(32'h300, 1'b1);
    chk("squashValid", instructionValid, 0);
    chk("squashAddr", fetchAddress, 32'h300);
    chk("squashErr", addrError, 0);
    instructionReady = 1'b1;
    expFetch.push_back(32'h300); expPC.push_back(32'h300);
    drain();
    stall = 1'b1;
    branch(32'h100, 1'b1);
    stall = 1'b0;
    expFetch.push_back(32'h100); expPC.push_back(32'h100);
    expFetch.push_back(32'h104); expPC.push_back(32'h104);
    drain();
    lat = 3;
    expFetch.push_back(32'h108);
    cyc();
    branch(32'h40, 1'b1);
    chk("outstandReq", fetchReq, 1);
    chk("outstandAddr", fetchAddress, 32'h108);
    expFetch.push_back(32'h40); expPC.push_back(32'h40);
    drain();
    stall = 1'b1;
    lat = 1;
    branch(32'hAABB_CCDF, 1'b1);
    chk("misErr", addrError, 1);
    chk("misAddr", fetchAddress, 32'hAABB_CCDC);
    stall = 1'b0;
    expFetch.push_back(32'hAABB_CCDC);
    drain();
    instructionReady = 1'b0;
    chk("misIPC", instructionPC, 32'hAABB_CCDC);
    chk("misSticky", addrError, 1);
    chk("misPcAddr", pcAddress, 32'hAABB_CCE0);
    rstN[0] = 1'b0;
    #1;
    chk("errCleared", addrError, 0);
    chk("rstValidEnd", instructionValid, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
